rv_test_monitor: RTL
====================

Name: rv_test_monitor

Overview:
Synthesisable end-of-test monitor for the riscvboy simple platform. It replaces the fixed-delay run and final x3 check with event-driven detection. It snoops the core's register-file write port, the retire stream and the store bus, and detects test termination through one of two modes: an ecall carrying a gp status value, or a tohost store. It reports pass, fail or timeout, together with the failing test number and cycle/instret statistics, to the bench or to an on-board status register.

Parameters:
XLEN, 32, data width of register and store buses
STATUS_REG, 3, register index watched as the test status (gp)
TOHOST_ADDR, 32'h0000_1000, store address treated as tohost
TIMEOUT_CYCLES, 100000, cycles in RUN before a timeout is declared (must be at least 2)
CNT_W, 32, width of the cycle and instret counters

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; arms the monitor and clears all results
mode  in  1  0 = ecall/register mode, 1 = tohost mode; sampled on start
rf_we  in  1  register-file write enable
rf_waddr  in  5  register-file write index
rf_wdata  in  XLEN  register-file write data
retire_valid  in  1  one instruction retired this cycle
retire_instr  in  32  encoding of the retired instruction
st_valid  in  1  store issued this cycle
st_addr  in  XLEN  store address
st_data  in  XLEN  store data
busy  out  1  monitor is in RUN
done  out  1  a result is latched (sticky)
pass  out  1  test passed (sticky)
fail  out  1  test failed (sticky)
timeout  out  1  timeout expired (sticky)
test_num  out  XLEN-1  failing test number, equal to status >> 1
status_val  out  XLEN  shadow of STATUS_REG, or the tohost data
cycle_count  out  CNT_W  cycles spent in RUN
instret_count  out  CNT_W  retires counted in RUN

Behaviour:
- Reset values: all outputs are 0 and the FSM is in IDLE. When rst and start are both high, rst wins.
- FSM states: IDLE, RUN, DONE.
  - IDLE goes to RUN on start.
  - RUN goes to DONE on a termination event or on timeout.
  - DONE goes to RUN on start (re-arm). Otherwise DONE holds all results.
- On start (from any state):
  - Latch mode.
  - Clear pass, fail, timeout, done, test_num, status_val and both counters.
  - Set busy on the next cycle.
- Shadow register (all modes, RUN only): if rf_we and rf_waddr == STATUS_REG, then status_val <= rf_wdata.
  - Writes with rf_waddr == 0 are ignored even if STATUS_REG == 0.
- Counters in RUN: cycle_count increments every cycle and instret_count increments on each retire_valid. Both saturate at all-ones and freeze outside RUN.
- Termination event, mode 0: retire_valid and retire_instr == 32'h0000_0073 (ecall).
  - The evaluated value V is rf_wdata if a STATUS_REG write occurs in the same cycle; otherwise it is status_val.
- Termination event, mode 1: st_valid, st_addr == TOHOST_ADDR and st_data != 0.
  - V = st_data, and status_val <= st_data.
  - A tohost store with data 0 is ignored.
- Evaluation (registered, visible the cycle after the event):
  - If V == 1: pass = 1.
  - Otherwise: fail = 1 and test_num = V[XLEN-1:1].
  - In both cases done = 1 and busy = 0.
  - The retire or cycle in which the event occurs is still counted.
- Timeout: when cycle_count == TIMEOUT_CYCLES-1 in RUN with no event, the next cycle shows timeout = 1, done = 1, busy = 0 and pass = fail = 0.
  - An event in that same cycle takes priority over timeout.
- Mode 0 ignores stores; mode 1 ignores ecall. Events in IDLE or DONE are ignored.
- Exactly one of pass, fail or timeout is set whenever done = 1.

Test Plan:
- Reset, then start with mode=0. Write x3=1, then retire ecall 0x00000073 at cycle 50 -> pass=1, done=1, busy=0 one cycle later; fail=0, timeout=0; status_val=1; cycle_count=51.
- Mode 0: x3=7 and ecall retire in the same cycle (previous shadow 1) -> fail=1, test_num=3, status_val=7. Repeat with rf_waddr=4 -> the write is ignored and pass=1.
- Mode 1: store 0 to TOHOST_ADDR (ignored), then store 5 to TOHOST_ADDR+4 (ignored), then store 5 to TOHOST_ADDR -> fail=1, test_num=2. A later ecall is ignored.
- TIMEOUT_CYCLES=16, no event -> timeout=1 on the cycle after cycle_count==15; pass=fail=0; counters frozen. With an ecall exactly at cycle_count==15 -> pass, and no timeout.
- In DONE, pulse start -> all results clear and busy=1 next cycle. Assert rst mid-RUN -> all outputs 0 next cycle. rst and start together -> stays in IDLE.
- 40 retires with instret_count CNT_W=4 -> saturates at 15. Retire ecall in IDLE -> no done.

Source files
------------

// File: rtl/rv_test_monitor_if.sv
// Snoop bundle for the end-of-test monitor: register-file write port, retire stream and store bus.
interface rv_test_monitor_if #(
    parameter int unsigned XLEN = 32
);
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            retire_valid;
    logic [31:0]     retire_instr;
    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;

    modport master (
        output rf_we, rf_waddr, rf_wdata,
        output retire_valid, retire_instr,
        output st_valid, st_addr, st_data
    );

    modport slave (
        input rf_we, rf_waddr, rf_wdata,
        input retire_valid, retire_instr,
        input st_valid, st_addr, st_data
    );
endinterface

// File: rtl/rv_test_monitor.sv
// Event-driven end-of-test monitor: detects ecall/gp or tohost termination,
// reports pass/fail/timeout with the failing test number and cycle/instret statistics.
module rv_test_monitor #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     STATUS_REG     = 3,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(32'h0000_1000),
    parameter int unsigned     TIMEOUT_CYCLES = 100000,
    parameter int unsigned     CNT_W          = 32
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    rv_test_monitor_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [XLEN-2:0]     test_num,
    output logic [XLEN-1:0]     status_val,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instret_count
);
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
    localparam logic [4:0]  STATUS_IDX  = 5'(STATUS_REG);
    localparam logic [63:0] TO_LAST     = 64'(TIMEOUT_CYCLES) - 64'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [XLEN-2:0]   test_num_q, test_num_d;
    logic [XLEN-1:0]   status_q, status_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ins_q, ins_d;

    logic              sh_wr;
    logic              ev_ecall;
    logic              ev_tohost;
    logic [XLEN-1:0]   v;

    // Writes to x0 never update the shadow, even if x0 is the watched register.
    assign sh_wr     = bus.rf_we && (bus.rf_waddr != 5'd0) && (bus.rf_waddr == STATUS_IDX);
    assign ev_ecall  = !mode_q && bus.retire_valid && (bus.retire_instr == ECALL_INSTR);
    assign ev_tohost = mode_q && bus.st_valid && (bus.st_addr == TOHOST_ADDR)
                       && (bus.st_data != '0);
    assign v         = mode_q ? bus.st_data : (sh_wr ? bus.rf_wdata : status_q);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            test_num_q <= '0;
            status_q   <= '0;
            cyc_q      <= '0;
            ins_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            test_num_q <= test_num_d;
            status_q   <= status_d;
            cyc_q      <= cyc_d;
            ins_q      <= ins_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        test_num_d = test_num_q;
        status_d   = status_q;
        cyc_d      = cyc_q;
        ins_d      = ins_q;

        if (state_q == ST_RUN) begin
            if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
            if (bus.retire_valid && (ins_q != '1)) ins_d = ins_q + CNT_W'(1);
            if (sh_wr) status_d = bus.rf_wdata;

            // A termination event in the final timeout cycle wins over the timeout.
            if (ev_ecall || ev_tohost) begin
                if (ev_tohost) status_d = bus.st_data;
                state_d = ST_DONE;
                done_d  = 1'b1;
                if (v == XLEN'(1)) begin
                    pass_d = 1'b1;
                end else begin
                    fail_d     = 1'b1;
                    test_num_d = v[XLEN-1:1];
                end
            end else if (64'(cyc_q) == TO_LAST) begin
                state_d   = ST_DONE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
        end

        if (start) begin
            state_d    = ST_RUN;
            mode_d     = mode;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            test_num_d = '0;
            status_d   = '0;
            cyc_d      = '0;
            ins_d      = '0;
        end

        busy_d = (state_d == ST_RUN);
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign timeout       = timeout_q;
    assign test_num      = test_num_q;
    assign status_val    = status_q;
    assign cycle_count   = cyc_q;
    assign instret_count = ins_q;
endmodule
